// File: rtl/sha256_msg_sched.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_msg_sched
//  Purpose  : SHA-256 message scheduler. Accepts one 512-bit padded block and
//             emits W_0..W_{NUM_ROUNDS-1} one word per valid/ready handshake.
//             A 16-word sliding window holds W_t..W_t+15. Each transfer
//             shifts the window by one word and appends the next schedule
//             word.
//  Revision : 1.0  initial release
// ============================================================================
module sha256_msg_sched #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_data,
    output logic [5:0]   w_idx,
    output logic         w_last,
    output logic         busy
);

    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_RUN      = 1'b1;
    localparam logic [5:0] c_LAST_IDX = 6'(NUM_ROUNDS - 1);

    // small sigma functions of the SHA-256 message expansion
    function automatic logic [31:0] f_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] f_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    logic [0:0]  r_state;
    logic [5:0]  r_t;
    logic [31:0] r_win [16];

    logic [31:0] w_blk_word [16];
    logic [31:0] w_next_word;
    logic        w_accept;
    logic        w_xfer;

    // Split the big-endian block into its sixteen 32-bit words (W_0 = MSBs)
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_unpack
            assign w_blk_word[gi] = blk_data[511 - 32*gi -: 32];
        end
    endgenerate

    assign w_accept = (r_state == c_IDLE) && blk_valid;
    assign w_xfer   = (r_state == c_RUN) && w_ready;

    // Single-cycle adder tree. The 32-bit result width discards the carries,
    // so the sum wraps modulo 2^32.
    assign w_next_word = f_sigma1(r_win[14]) + r_win[9] + f_sigma0(r_win[1]) + r_win[0];

    // Control: word index and IDLE/RUN sequencing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_t     <= '0;
        end else if (w_accept) begin
            r_state <= c_RUN;
            r_t     <= '0;
        end else if (w_xfer) begin
            if (r_t == c_LAST_IDX) begin
                r_state <= c_IDLE;
                r_t     <= '0;
            end else begin
                r_t <= r_t + 6'd1;
            end
        end
    end

    // Window: load on block acceptance, shift-and-append on every transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 16; k++) begin
                r_win[k] <= '0;
            end
        end else if (w_accept) begin
            for (int k = 0; k < 16; k++) begin
                r_win[k] <= w_blk_word[k];
            end
        end else if (w_xfer) begin
            for (int k = 0; k < 15; k++) begin
                r_win[k] <= r_win[k+1];
            end
            r_win[15] <= w_next_word;
        end
    end

    // All outputs decode directly from registers; no combinational path from inputs.
    assign blk_ready = (r_state == c_IDLE);
    assign w_valid   = (r_state == c_RUN);
    assign busy      = (r_state == c_RUN);
    assign w_data    = r_win[0];
    assign w_idx     = r_t;
    assign w_last    = (r_t == c_LAST_IDX);

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha256_msg_sched
//  Purpose  : Self-checking bench for sha256_msg_sched (64-round and 17-round
//             builds). Expected words come from a direct W_t recurrence model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sha256_msg_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         blk_valid, blk_ready;
    logic [511:0] blk_data;
    logic         w_valid, w_ready;
    logic [31:0]  w_data;
    logic [5:0]   w_idx;
    logic         w_last, busy;

    logic         blk_valid17, blk_ready17;
    logic [511:0] blk_data17;
    logic         w_valid17, w_ready17;
    logic [31:0]  w_data17;
    logic [5:0]   w_idx17;
    logic         w_last17, busy17;

    sha256_msg_sched #(.NUM_ROUNDS(64)) dut (
        .clk(clk), .reset(reset),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_idx(w_idx), .w_last(w_last), .busy(busy)
    );

    sha256_msg_sched #(.NUM_ROUNDS(17)) dut17 (
        .clk(clk), .reset(reset),
        .blk_valid(blk_valid17), .blk_ready(blk_ready17), .blk_data(blk_data17),
        .w_valid(w_valid17), .w_ready(w_ready17), .w_data(w_data17),
        .w_idx(w_idx17), .w_last(w_last17), .busy(busy17)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0]  ref_w [0:63];
    logic [31:0]  obs_w [0:63];
    logic [511:0] abc_blk;
    logic [511:0] ones_blk;
    logic [511:0] rnd_blk;
    int           cyc;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Textbook schedule: W_t = s1(W_t-2) + W_t-7 + s0(W_t-15) + W_t-16 mod 2^32
    task automatic build_ref(input logic [511:0] blk);
        longint sum;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                ref_w[t] = blk[511 - 32*t -: 32];
            end else begin
                sum = longint'(ref_s1(ref_w[t-2])) + longint'(ref_w[t-7])
                    + longint'(ref_s0(ref_w[t-15])) + longint'(ref_w[t-16]);
                ref_w[t] = 32'(sum % 64'h1_0000_0000);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_w_valid"},   32'(w_valid),   32'd0);
        chk({tag, "_blk_ready"}, 32'(blk_ready), 32'd1);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_w_idx"},     32'(w_idx),     32'd0);
        chk({tag, "_w_last"},    32'(w_last),    32'd0);
    endtask

    task automatic start_block(input logic [511:0] blk);
        @(negedge clk);
        chk("start_blk_ready", 32'(blk_ready), 32'd1);
        blk_valid = 1'b1;
        blk_data  = blk;
    endtask

    // Consume n_words against ref_w with random stalls; checks stability while stalled.
    task automatic drain(input int n_words, input int stall_pct, input bit hold_valid,
                         input logic [511:0] next_data, output int cycles);
        int          t = 0;
        bit          stalled = 1'b0;
        logic [31:0] pd = '0;
        logic [5:0]  pi = '0;
        cycles = 0;
        while (t < n_words && cycles < 4000) begin
            @(negedge clk);
            cycles++;
            blk_valid = hold_valid;
            blk_data  = next_data;
            if (stalled) begin
                chk("stall_w_data", w_data, pd);
                chk("stall_w_idx", 32'(w_idx), 32'(pi));
            end
            chk("w_valid",   32'(w_valid),   32'd1);
            chk("busy",      32'(busy),      32'd1);
            chk("blk_ready", 32'(blk_ready), 32'd0);
            chk("w_idx",     32'(w_idx),     32'(t));
            chk("w_data",    w_data,         ref_w[t]);
            chk("w_last",    32'(w_last),    32'(t == 63));
            obs_w[t] = w_data;
            w_ready  = ($urandom_range(99) >= 32'(stall_pct)) ? 1'b1 : 1'b0;
            stalled  = !w_ready;
            pd       = w_data;
            pi       = w_idx;
            if (w_ready) t++;
        end
        chk("drain_words", 32'(t), 32'(n_words));
    endtask

    initial begin
        reset       = 1'b1;
        blk_valid   = 1'b0;
        blk_data    = '0;
        w_ready     = 1'b1;
        blk_valid17 = 1'b0;
        blk_data17  = '0;
        w_ready17   = 1'b1;
        abc_blk     = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0]    = 32'h00000018;
        ones_blk    = '1;

        // Step 1: reset, then idle with blk_valid low
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            idle_chk("idle");
            chk("idle_w_data", w_data, 32'd0);
        end

        // Step 2: "abc" block, w_ready tied high
        build_ref(abc_blk);
        start_block(abc_blk);
        drain(64, 0, 1'b0, {16{$urandom()}}, cyc);
        chk("abc_cycles", 32'(cyc), 32'd64);
        chk("abc_w0",  obs_w[0],  32'h61626380);
        chk("abc_w15", obs_w[15], 32'h00000018);
        chk("abc_w16", obs_w[16], 32'h61626380);
        chk("abc_w17", obs_w[17], 32'h000F0000);
        @(negedge clk);
        idle_chk("abc_end");

        // Step 3: same block with ~40% stalls
        start_block(abc_blk);
        drain(64, 40, 1'b0, {16{$urandom()}}, cyc);
        @(negedge clk);
        idle_chk("stall_end");

        // Step 4: random blocks with random stalls
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 16; k++) rnd_blk[511 - 32*k -: 32] = $urandom();
            build_ref(rnd_blk);
            start_block(rnd_blk);
            drain(64, 30, 1'b0, {16{$urandom()}}, cyc);
        end

        // Step 5: back-to-back, blk_valid held high, second block all ones
        build_ref(abc_blk);
        start_block(abc_blk);
        drain(64, 20, 1'b1, ones_blk, cyc);
        @(negedge clk);
        idle_chk("b2b_gap");
        build_ref(ones_blk);
        drain(64, 0, 1'b0, {16{$urandom()}}, cyc);
        chk("b2b_cycles", 32'(cyc), 32'd64);
        chk("b2b_w0", obs_w[0], 32'hFFFFFFFF);

        // Step 6: asynchronous reset mid-stall at w_idx=30
        build_ref(abc_blk);
        start_block(abc_blk);
        drain(30, 30, 1'b0, {16{$urandom()}}, cyc);
        @(negedge clk);
        w_ready = 1'b0;
        chk("pre_reset_w_idx", 32'(w_idx), 32'd30);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        idle_chk("async_reset");
        chk("async_reset_w_data", w_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        idle_chk("post_reset");
        start_block(abc_blk);
        drain(64, 25, 1'b0, {16{$urandom()}}, cyc);
        @(negedge clk);
        idle_chk("post_reset_end");

        // Step 7: 17-round build, "abc" block, w_ready high
        @(negedge clk);
        chk("r17_blk_ready", 32'(blk_ready17), 32'd1);
        blk_valid17 = 1'b1;
        blk_data17  = abc_blk;
        for (int t = 0; t < 17; t++) begin
            @(negedge clk);
            blk_valid17 = 1'b0;
            blk_data17  = '0;
            chk("r17_w_valid", 32'(w_valid17), 32'd1);
            chk("r17_busy",    32'(busy17),    32'd1);
            chk("r17_w_idx",   32'(w_idx17),   32'(t));
            chk("r17_w_data",  w_data17,       ref_w[t]);
            chk("r17_w_last",  32'(w_last17),  32'(t == 16));
        end
        @(negedge clk);
        chk("r17_end_w_valid",   32'(w_valid17),   32'd0);
        chk("r17_end_blk_ready", 32'(blk_ready17), 32'd1);
        chk("r17_end_w_idx",     32'(w_idx17),     32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
